// File: rtl/fa_cell.sv
// fa_cell: 1-bit full-adder cell, the leaf of the ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with an optional registered output stage.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    assign c[0] = ci;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum_d[i]),
            .co (c[i+1])
        );
    end
    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;
        // Sum/carry are captured every cycle; out_valid alone qualifies them.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= c[WIDTH];
                valid_q <= in_valid;
            end
        end
        assign sum       = sum_q;
        assign carry     = carry_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic unused_ok;
        assign unused_ok = ^{clk, rst, in_valid};
        assign sum       = sum_d;
        assign carry     = c[WIDTH];
        assign out_valid = 1'b1;
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder in several configurations.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic a1, b1, ci1, s1, c1, v1;
    full_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1), .in_valid(1'b0),
        .sum(s1), .carry(c1), .out_valid(v1));

    logic [7:0] a8, b8, s8c, s8r;
    logic       ci8, iv8, c8c, c8r, v8c, v8r;
    full_adder #(.WIDTH(8), .OUT_REG(1'b0)) u_w8c (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8), .in_valid(iv8),
        .sum(s8c), .carry(c8c), .out_valid(v8c));
    full_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_w8r (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8), .in_valid(iv8),
        .sum(s8r), .carry(c8r), .out_valid(v8r));

    logic [15:0] a16, b16, s16c, s16r;
    logic        ci16, iv16, c16c, c16r, v16c, v16r;
    full_adder #(.WIDTH(16), .OUT_REG(1'b0)) u_w16c (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .ci(ci16), .in_valid(iv16),
        .sum(s16c), .carry(c16c), .out_valid(v16c));
    full_adder #(.WIDTH(16), .OUT_REG(1'b1)) u_w16r (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .ci(ci16), .in_valid(iv16),
        .sum(s16r), .carry(c16r), .out_valid(v16r));

    task automatic test_reset;
        #3;
        total++;
        if ({s8r, c8r, v8r} !== 10'b0) begin
            bad++;
            $display("FAIL reset_w8 got sum=%h carry=%b valid=%b want 00 0 0", s8r, c8r, v8r);
        end
        total++;
        if ({s16r, c16r, v16r} !== 18'b0) begin
            bad++;
            $display("FAIL reset_w16 got sum=%h carry=%b valid=%b want 0000 0 0", s16r, c16r, v16r);
        end
        total++;
        if (v8c !== 1'b1 || v1 !== 1'b1) begin
            bad++;
            $display("FAIL comb_valid got %b/%b want 1/1", v8c, v1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_table;
        logic [1:0] exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, b1, ci1} = v;
            #1;
            total++;
            if ({c1, s1} !== exp[i]) begin
                bad++;
                $display("FAIL truth_%0d got carry,sum=%b%b want %b", i, c1, s1, exp[i]);
            end
        end
    endtask

    task automatic test_comb8;
        logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h3C};
        logic [7:0] vb [3] = '{8'h00, 8'hFF, 8'h41};
        logic       vc [3] = '{1'b1, 1'b1, 1'b0};
        logic [8:0] ex [3] = '{9'h100, 9'h1FF, 9'h07D};
        for (int i = 0; i < 3; i++) begin
            a8 = va[i]; b8 = vb[i]; ci8 = vc[i];
            #1;
            total++;
            if ({c8c, s8c} !== ex[i]) begin
                bad++;
                $display("FAIL comb8_%0d got %h want %h", i, {c8c, s8c}, ex[i]);
            end
        end
        a16 = 16'h0000; b16 = 16'h0000; ci16 = 1'b0;
        #1;
        total++;
        if ({c16c, s16c} !== 17'h0) begin
            bad++;
            $display("FAIL zero16 got %h want 0", {c16c, s16c});
        end
    endtask

    task automatic test_pipe;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({v8r, c8r, s8r} !== 10'h300) begin
            bad++;
            $display("FAIL pipe_edgeN got v=%b c=%b s=%h want 1 1 00", v8r, c8r, s8r);
        end
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; iv8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({v8r, c8r, s8r} !== 10'h003) begin
            bad++;
            $display("FAIL pipe_edgeN1 got v=%b c=%b s=%h want 0 0 03", v8r, c8r, s8r);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h06; ci8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({v8r, c8r, s8r} !== 10'h20C) begin
            bad++;
            $display("FAIL pre_rst got v=%b c=%b s=%h want 1 0 0c", v8r, c8r, s8r);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({v8r, c8r, s8r} !== 10'h000) begin
            bad++;
            $display("FAIL rst_async got v=%b c=%b s=%h want 0 0 00", v8r, c8r, s8r);
        end
        rst = 1'b0;
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
        #1;
        total++;
        if ({v8r, c8r, s8r} !== 10'h000) begin
            bad++;
            $display("FAIL rst_hold got v=%b c=%b s=%h want 0 0 00", v8r, c8r, s8r);
        end
        @(posedge clk); #1;
        total++;
        if ({v8r, c8r, s8r} !== 10'h230) begin
            bad++;
            $display("FAIL post_rst got v=%b c=%b s=%h want 1 0 30", v8r, c8r, s8r);
        end
    endtask

    task automatic test_back_to_back;
        int errs_c = 0;
        int errs_r = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [16:0] exp;
            logic        v;
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); v = 1'($urandom);
            iv16 = v;
            exp = {1'b0, a16} + {1'b0, b16} + {16'b0, ci16};
            #1;
            total++;
            if ({c16c, s16c} !== exp) begin
                bad++; errs_c++;
                if (errs_c < 5) $display("FAIL rand_comb got %h want %h", {c16c, s16c}, exp);
            end
            @(posedge clk); #1;
            total++;
            if ({v16r, c16r, s16r} !== {v, exp}) begin
                bad++; errs_r++;
                if (errs_r < 5) $display("FAIL rand_reg got %h want %h", {v16r, c16r, s16r}, {v, exp});
            end
        end
    endtask

    initial begin
        a1 = 0; b1 = 0; ci1 = 0;
        a8 = 0; b8 = 0; ci8 = 0; iv8 = 0;
        a16 = 0; b16 = 0; ci16 = 0; iv16 = 0;
        test_reset;
        test_truth_table;
        test_comb8;
        test_pipe;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
